mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_store_merge.sv | 32 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: size codes,
// FSM states, the default starvation limit and the alignment rule.
package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_WRITE,
    ST_RESP
  } state_t;

  // The reserved size code 2'b11 is treated as an unserviceable access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = offset[0];
      SIZE_WORD: misaligned = (offset != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_store_merge.sv
// Combinational big-endian lane merge of partial store data into an existing word.
module store_merge
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd0: new_word[31:24] = wdata[7:0];
          2'd1: new_word[23:16] = wdata[7:0];
          2'd2: new_word[15:8]  = wdata[7:0];
          2'd3: new_word[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) new_word[15:0]  = wdata[15:0];
        else           new_word[31:16] = wdata[15:0];
      end
      SIZE_WORD: new_word = wdata;
      default:   new_word = old_word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// synchronous memory, with read-modify-write for sub-word stores.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_t        state, state_next;
  logic          is_data;
  logic [31:0]   addr_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] starve_cnt;
  logic          starved, idle, grant_i, grant_d;
  logic          bad, word_store, sub_store;
  logic [31:0]   merged;

  // Fetch wins only when alone or once data has starved it for STARVE_LIMIT grants.
  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
  assign idle    = (state == ST_IDLE) && reset_n;
  assign grant_i = idle && i_req_valid && (!d_req_valid || starved);
  assign grant_d = idle && d_req_valid && !grant_i;

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  assign bad        = is_data && misaligned(size_q, addr_q[1:0]);
  assign word_store = is_data && we_q && !bad && (size_q == SIZE_WORD);
  assign sub_store  = is_data && we_q && !bad && (size_q != SIZE_WORD);
  assign mem_addr   = {addr_q[31:2], 2'b00};

  store_merge u_store_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .size     (size_q),
    .offset   (addr_q[1:0]),
    .new_word (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_data <= 1'b0;
      addr_q  <= '0;
      size_q  <= SIZE_WORD;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_i) begin
      is_data <= 1'b0;
      addr_q  <= i_req_addr;
      size_q  <= SIZE_WORD;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_d) begin
      is_data <= 1'b1;
      addr_q  <= d_req_addr;
      size_q  <= d_req_size;
      we_q    <= d_req_we;
      wdata_q <= d_req_wdata;
    end
  end

  // Only contended data grants count toward starvation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 starve_cnt <= '0;
    else if (grant_i)                             starve_cnt <= '0;
    else if (grant_d && i_req_valid && !starved)  starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    state_next  = state;
    i_rsp_valid = 1'b0;
    i_rsp_data  = '0;
    d_rsp_valid = 1'b0;
    d_rsp_data  = '0;
    d_rsp_err   = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    case (state)
      ST_IDLE: begin
        if (grant_i || grant_d) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (word_store) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
        state_next = sub_store ? ST_RMW_WRITE : ST_RESP;
      end
      ST_RMW_WRITE: begin
        mem_we     = 1'b1;
        mem_wdata  = merged;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        if (is_data) begin
          d_rsp_valid = 1'b1;
          d_rsp_err   = bad;
          d_rsp_data  = (!we_q && !bad) ? mem_rdata : '0;
        end else begin
          i_rsp_valid = 1'b1;
          i_rsp_data  = mem_rdata;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a transaction-level
// model of grant policy, response timing and memory contents.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_val;

  logic [31:0] ref_mem [256];
  int          model_starve;
  int          n_compared, n_mismatched;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .i_req_ready (i_req_ready),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .d_req_valid (d_req_valid),
    .d_req_we    (d_req_we),
    .d_req_size  (d_req_size),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_req_ready (d_req_ready),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_data  (d_rsp_data),
    .d_rsp_err   (d_rsp_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Synchronous single-port memory with a backdoor load port.
  always @(posedge clk) begin
    if (bd_we)       mem[bd_idx] <= bd_val;
    else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    bd_idx = idx;
    bd_val = val;
    bd_we  = 1'b1;
    ref_mem[idx] = val;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    int          sh;
    logic [31:0] mask;
    if (sz == 2'd2) return wd;
    if (sz == 2'd0) begin
      sh   = 8 * (3 - int'(off));
      mask = 32'hFF << sh;
      return (old & ~mask) | ((wd & 32'hFF) << sh);
    end
    sh   = off[1] ? 0 : 16;
    mask = 32'hFFFF << sh;
    return (old & ~mask) | ((wd & 32'hFFFF) << sh);
  endfunction

  // One transaction from an idle arbiter, observed over the following four cycles.
  task automatic applyStimulus(input bit use_i, input bit use_d, input logic [31:0] ia,
                               input bit we, input logic [1:0] sz, input logic [31:0] da,
                               input logic [31:0] wd, output logic [31:0] obs_wdata,
                               output logic [31:0] obs_data, output logic obs_err);
    bit          grant_d, bad, wstore, sstore, exp_we;
    int          rsp_c;
    logic [31:0] exp_addr, exp_data, exp_wdata;
    grant_d   = use_d && !(use_i && model_starve == LIMIT);
    bad       = grant_d && ((sz == 2'd1 && da[0]) || (sz == 2'd2 && da[1:0] != 2'd0) || sz == 2'd3);
    wstore    = grant_d && we && !bad && sz == 2'd2;
    sstore    = grant_d && we && !bad && sz != 2'd2;
    exp_addr  = grant_d ? {da[31:2], 2'b00} : {ia[31:2], 2'b00};
    exp_wdata = model_merge(ref_mem[exp_addr[9:2]], wd, sz, da[1:0]);
    exp_data  = (!grant_d || (!we && !bad)) ? ref_mem[exp_addr[9:2]] : 32'd0;
    rsp_c     = sstore ? 3 : 2;
    obs_wdata = '0;
    obs_data  = '0;
    obs_err   = 1'b0;
    @(negedge clk);
    i_req_valid = use_i;
    i_req_addr  = ia;
    d_req_valid = use_d;
    d_req_we    = we;
    d_req_size  = sz;
    d_req_addr  = da;
    d_req_wdata = wd;
    #1;
    checkOutput("i_ready", 32'(i_req_ready), 32'(use_i && !grant_d));
    checkOutput("d_ready", 32'(d_req_ready), 32'(grant_d));
    if (grant_d) begin
      if (use_i && model_starve < LIMIT) model_starve++;
    end else begin
      model_starve = 0;
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
      end
      #1;
      exp_we = (wstore && c == 1) || (sstore && c == 2);
      checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
      if (mem_we) obs_wdata = mem_wdata;
      if (c == 1) checkOutput("access_addr", mem_addr, exp_addr);
      if (exp_we) begin
        checkOutput("mem_wdata", mem_wdata, exp_wdata);
        checkOutput("write_addr", mem_addr, exp_addr);
      end
      checkOutput("i_rsp_valid", 32'(i_rsp_valid), 32'(!grant_d && c == rsp_c));
      checkOutput("d_rsp_valid", 32'(d_rsp_valid), 32'(grant_d && c == rsp_c));
      if (c == rsp_c) begin
        obs_data = grant_d ? d_rsp_data : i_rsp_data;
        obs_err  = d_rsp_err;
        checkOutput("rsp_data", obs_data, exp_data);
        if (grant_d) checkOutput("d_rsp_err", 32'(d_rsp_err), 32'(bad));
      end
    end
    if (wstore || sstore) ref_mem[exp_addr[9:2]] = exp_wdata;
  endtask

  initial begin
    logic [31:0] ow, od;
    logic        oe;
    bit          exp_i;
    n_compared   = 0;
    n_mismatched = 0;
    model_starve = 0;
    bd_we        = 1'b0;
    bd_idx       = '0;
    bd_val       = '0;
    reset_n      = 1'b0;
    i_req_valid  = 1'b1;
    i_req_addr   = 32'h40;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b1;
    d_req_size   = 2'd2;
    d_req_addr   = 32'h200;
    d_req_wdata  = 32'hFFFF_FFFF;
    #2;
    checkOutput("rst_i_ready", 32'(i_req_ready), 0);
    checkOutput("rst_d_ready", 32'(d_req_ready), 0);
    checkOutput("rst_mem_we", 32'(mem_we), 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_i_rsp_valid", 32'(i_rsp_valid), 0);
    checkOutput("rst_d_rsp_valid", 32'(d_rsp_valid), 0);
    checkOutput("rst_d_rsp_err", 32'(d_rsp_err), 0);
    checkOutput("rst_rsp_data", i_rsp_data | d_rsp_data, 0);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    @(negedge clk);
    reset_n = 1'b1;

    poke(8'h10, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 32'h40, 0, 2'd2, 32'h0, 32'h0, ow, od, oe);
    checkOutput("fetch_deadbeef", od, 32'hDEAD_BEEF);

    poke(8'h40, 32'h1122_3344);
    applyStimulus(0, 1, 32'h0, 1, 2'd0, 32'h101, 32'hAB, ow, od, oe);
    checkOutput("sb_merged", ow, 32'h11AB_3344);

    poke(8'h40, 32'h1122_3344);
    applyStimulus(0, 1, 32'h0, 1, 2'd1, 32'h102, 32'hCAFE, ow, od, oe);
    checkOutput("sh_merged", ow, 32'h1122_CAFE);
    applyStimulus(0, 1, 32'h0, 1, 2'd1, 32'h103, 32'hBEEF, ow, od, oe);
    checkOutput("sh_misaligned_err", 32'(oe), 1);

    applyStimulus(0, 1, 32'h0, 1, 2'd2, 32'h200, 32'h1234_5678, ow, od, oe);
    applyStimulus(0, 1, 32'h0, 0, 2'd2, 32'h200, 32'h0, ow, od, oe);
    checkOutput("lw_after_sw", od, 32'h1234_5678);
    checkOutput("lw_err", 32'(oe), 0);

    for (int k = 0; k < 200; k++) begin
      bit ui, ud;
      ui = 1'($urandom_range(0, 1));
      ud = 1'($urandom_range(0, 1));
      if (!ui && !ud) ud = 1'b1;
      applyStimulus(ui, ud, 32'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 2)), 32'($urandom_range(0, 1023)), $urandom,
                    ow, od, oe);
    end

    // Both requesters held valid: observe the grant order and busy-cycle readys.
    applyStimulus(1, 0, 32'h40, 0, 2'd2, 32'h0, 32'h0, ow, od, oe);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_addr  = 32'h40;
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_size  = 2'd2;
    d_req_addr  = 32'h200;
    for (int g = 0; g < 10; g++) begin
      #1;
      exp_i = (model_starve == LIMIT);
      checkOutput("grant_i", 32'(i_req_ready), 32'(exp_i));
      checkOutput("grant_d", 32'(d_req_ready), 32'(!exp_i));
      if (exp_i) model_starve = 0;
      else if (model_starve < LIMIT) model_starve++;
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        #1;
        checkOutput("busy_readys", {30'd0, i_req_ready, d_req_ready}, 0);
      end
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset asserted during the RMW write cycle of a byte store.
    poke(8'h40, 32'h1122_3344);
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_size  = 2'd0;
    d_req_addr  = 32'h101;
    d_req_wdata = 32'hAB;
    #1;
    checkOutput("rmw_rst_d_ready", 32'(d_req_ready), 1);
    @(negedge clk);
    d_req_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rmw_rst_we_before", 32'(mem_we), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("rmw_rst_we_dropped", 32'(mem_we), 0);
    checkOutput("rmw_rst_mem_addr", mem_addr, 0);
    model_starve = 0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      #1;
      checkOutput("rmw_rst_no_rsp", 32'(d_rsp_valid), 0);
      if (r == 1) reset_n = 1'b1;
    end
    d_req_valid = 1'b1;
    #1;
    checkOutput("post_rst_d_ready", 32'(d_req_ready), 1);
    d_req_valid = 1'b0;
    i_req_valid = 1'b1;
    #1;
    checkOutput("post_rst_i_ready", 32'(i_req_ready), 1);
    i_req_valid = 1'b0;
    applyStimulus(0, 1, 32'h0, 0, 2'd2, 32'h100, 32'h0, ow, od, oe);
    checkOutput("rmw_rst_word_kept", od, 32'h1122_3344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
